// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I main decoder: opcodes, immediate
// formats, ALU operation classes and the packed control word.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_word_t;

endpackage

// File: rtl/riscv_main_decoder_if.sv
// Opcode-in / control-word-out bundle for the main decoder.
// master = instruction source (drives Op/OpValid), slave = decoder.
interface riscv_main_decoder_if;
  logic [6:0] Op;
  logic       OpValid;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic       ALUSrc;
  logic       MemWrite;
  logic       ResultSrc;
  logic       Branch;
  logic [1:0] ALUOp;
  logic       CtrlValid;
  logic       IllegalOp;

  modport master (
    output Op, OpValid,
    input  RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp,
           CtrlValid, IllegalOp
  );

  modport slave (
    input  Op, OpValid,
    output RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp,
           CtrlValid, IllegalOp
  );
endinterface

// File: rtl/riscv_main_decoder_main_dec_lut.sv
// Purely combinational opcode -> control word lookup.
// Optional I-type ALU decode enabled by defining MAIN_DEC_ITYPE_EN.
module main_dec_lut
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output ctrl_word_t ctrl,
  output logic       illegal
);

  // Decode table; unlisted opcodes (and, in simulation, X/Z opcodes, which
  // match no case item) fall to default with an all-zero word.
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (op)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        ctrl.imm_src   = IMM_S;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        ctrl.imm_src = IMM_B;
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALUOP_SUB;
      end
`ifdef MAIN_DEC_ITYPE_EN
      OP_ITYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
`endif
      default: begin
        ctrl    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/riscv_main_decoder.sv
// RV32I main control decoder: combinational lookup, OpValid gating, then one
// register stage so the control word lines up with the pipelined fetch.
// Optional feature macro: MAIN_DEC_ITYPE_EN (I-type ALU opcode decode).
module riscv_main_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  riscv_main_decoder_if.slave  bus
);

  ctrl_word_t lut_ctrl;
  logic       lut_illegal;

  ctrl_word_t ctrl_d, ctrl_q;
  logic       valid_d, valid_q;
  logic       illegal_d, illegal_q;

  main_dec_lut u_lut (
    .op      (bus.Op),
    .ctrl    (lut_ctrl),
    .illegal (lut_illegal)
  );

  // Bubbles (OpValid=0) become an all-zero word that cannot write state.
  always_comb begin
    ctrl_d    = '0;
    illegal_d = 1'b0;
    valid_d   = bus.OpValid;
    if (bus.OpValid) begin
      ctrl_d    = lut_ctrl;
      illegal_d = lut_illegal;
    end
  end

  // Output register; reset clears the whole word, discarding anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.RegWrite  = ctrl_q.reg_write;
  assign bus.ImmSrc    = ctrl_q.imm_src;
  assign bus.ALUSrc    = ctrl_q.alu_src;
  assign bus.MemWrite  = ctrl_q.mem_write;
  assign bus.ResultSrc = ctrl_q.result_src;
  assign bus.Branch    = ctrl_q.branch;
  assign bus.ALUOp     = ctrl_q.alu_op;
  assign bus.CtrlValid = valid_q;
  assign bus.IllegalOp = illegal_q;

endmodule

// File: tb/tb_riscv_main_decoder.sv
// Directed bench for riscv_main_decoder. Observed word packs
// {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, CtrlValid, IllegalOp}.
module tb_riscv_main_decoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  riscv_main_decoder_if bus ();

  riscv_main_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {bus.RegWrite, bus.ImmSrc, bus.ALUSrc, bus.MemWrite, bus.ResultSrc,
                bus.Branch, bus.ALUOp, bus.CtrlValid, bus.IllegalOp};

  // Expected words, hand-derived from the decode table.
  localparam logic [10:0] W_ZERO  = 11'b0_00_0_0_0_0_00_0_0;
  localparam logic [10:0] W_LW    = 11'b1_00_1_0_1_0_00_1_0;
  localparam logic [10:0] W_SW    = 11'b0_01_1_1_0_0_00_1_0;
  localparam logic [10:0] W_RT    = 11'b1_00_0_0_0_0_10_1_0;
  localparam logic [10:0] W_BEQ   = 11'b0_10_0_0_0_1_01_1_0;
  localparam logic [10:0] W_ILL   = 11'b0_00_0_0_0_0_00_1_1;
  localparam logic [10:0] W_ITYPE = 11'b1_00_1_0_0_0_10_1_0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.Op = 7'b0000011; bus.OpValid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs !== W_ZERO) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, W_ZERO);
      end
    end
    rst = 1'b0;
    tick();
    total++;
    if (obs !== W_LW) begin
      bad++;
      $display("FAIL reset_release_lw: got %b want %b", obs, W_LW);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [4] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011};
    logic [10:0] exp [4] = '{W_LW, W_SW, W_RT, W_BEQ};
    bus.OpValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Op = ops[i];
      if (i > 0) begin
        #1;
        total++;
        if (obs !== exp[i-1]) begin
          bad++;
          $display("FAIL b2b_hold[%0d]: got %b want %b", i, obs, exp[i-1]);
        end
      end
      tick();
      total++;
      if (obs !== exp[i]) begin
        bad++;
        $display("FAIL b2b_word[%0d]: got %b want %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [3] = '{7'b1111111, 7'b0000000, 7'b0110111};
    bus.OpValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.Op = ops[i];
      tick();
      total++;
      if (obs !== W_ILL) begin
        bad++;
        $display("FAIL illegal[%b]: got %b want %b", ops[i], obs, W_ILL);
      end
    end
    bus.Op = 7'bxxxxxxx;
    tick();
    total++;
    if (obs !== W_ILL) begin
      bad++;
      $display("FAIL illegal_x: got %b want %b", obs, W_ILL);
    end
  endtask

  task automatic test_bubble();
    bus.Op = 7'b0110011; bus.OpValid = 1'b0;
    tick();
    total++;
    if (obs !== W_ZERO) begin
      bad++;
      $display("FAIL bubble_rtype: got %b want %b", obs, W_ZERO);
    end
    bus.Op = 7'b1111111;
    tick();
    total++;
    if (obs !== W_ZERO) begin
      bad++;
      $display("FAIL bubble_illegal: got %b want %b", obs, W_ZERO);
    end
  endtask

  task automatic test_itype();
    logic [10:0] exp;
`ifdef MAIN_DEC_ITYPE_EN
    exp = W_ITYPE;
`else
    exp = W_ILL;
`endif
    bus.Op = 7'b0010011; bus.OpValid = 1'b1;
    tick();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL itype: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_reset_midstream();
    bus.Op = 7'b0100011; bus.OpValid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      rst = (c == 3 || c == 4);
      tick();
      total++;
      if (bus.MemWrite !== (c < 3 || c == 5)) begin
        bad++;
        $display("FAIL midrst_memwrite[c%0d]: got %b want %b", c, bus.MemWrite, (c < 3 || c == 5));
      end
      total++;
      if (obs !== ((c == 3 || c == 4) ? W_ZERO : W_SW)) begin
        bad++;
        $display("FAIL midrst_word[c%0d]: got %b", c, obs);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; bus.Op = '0; bus.OpValid = 1'b0;
    #2;
    test_reset();
    test_back_to_back();
    test_illegal();
    test_bubble();
    test_itype();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_main_decoder.md
Name: riscv_main_decoder

Overview:
Main control decoder for the single-cycle RV32I core. It maps the 7-bit instruction opcode to the datapath control signals: register write, immediate format, ALU source, memory write, result select, branch, and ALU operation class. Decoding is combinational. The control word is then registered once so it aligns with the pipelined-fetch variant of the core. The ALU decoder consumes `ALUOp` downstream.

Parameters:
None. Opcode and encoding constants live in the shared package.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- Op  input  7  instruction opcode, bits [6:0]
- OpValid  input  1  Op is meaningful this cycle
- RegWrite  output  1  write-back enable for the register file
- ImmSrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=reserved
- ALUSrc  output  1  0 = rs2, 1 = immediate
- MemWrite  output  1  data-memory write enable
- ResultSrc  output  1  0 = ALU result, 1 = memory read data
- Branch  output  1  instruction is a conditional branch
- ALUOp  output  2  00=add, 01=subtract/compare, 10=funct-decoded
- CtrlValid  output  1  registered copy of OpValid
- IllegalOp  output  1  the registered opcode was not recognised

Behaviour:
- The control word is formed combinationally from Op and captured on the rising edge of clk. All outputs are registered, with latency of exactly 1 cycle from Op/OpValid to the outputs.
- Synchronous reset (rst=1 at a clock edge) sets every output to 0, including CtrlValid and IllegalOp. Reset dominates OpValid. Reset asserted mid-stream discards the in-flight word.
- OpValid=0 at an edge: all control outputs register to 0, CtrlValid=0, IllegalOp=0. This is a bubble and can never write state.
- Decode table, listed as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp:
  - 0000011 (lw): 1, 00, 1, 0, 1, 0, 00
  - 0100011 (sw): 0, 01, 1, 1, 0, 0, 00
  - 0110011 (R-type): 1, 00, 0, 0, 0, 0, 10
  - 1100011 (beq): 0, 10, 0, 0, 0, 1, 01
  - Any other opcode: all control outputs 0 and IllegalOp=1 (when OpValid=1).
- Don't-care fields are fixed to 0 (ImmSrc for R-type; ResultSrc for sw and beq) so that outputs are fully deterministic.
- The outputs never carry X. An X or Z on Op is treated as illegal only in simulation; synthesis ignores this.
- Back-to-back opcodes on consecutive cycles each produce their own word one cycle later, with no interaction between them.

Optional Feature:
- Macro: MAIN_DEC_ITYPE_EN.
- When defined, opcode 0010011 (I-type ALU, e.g. addi) decodes to 1, 00, 1, 0, 0, 0, 10 with IllegalOp=0.
- When undefined, 0010011 falls to the default case: all controls 0 and IllegalOp=1.
- No other behaviour changes.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode localparams: OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE;
  - ImmSrc encodings: IMM_I, IMM_S, IMM_B;
  - ALUOp encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - a packed control-word typedef ctrl_word_t.
- One sub-module: main_dec_lut, a purely combinational Op → ctrl_word_t plus illegal flag. The top level adds the OpValid gating and the output register.

Test Plan:
- Reset: rst=1 for 2 cycles with Op=0000011 and OpValid=1 → all outputs 0. Release rst → on the next edge, RegWrite=1, ALUSrc=1, ResultSrc=1, ImmSrc=00, ALUOp=00.
- Sequence lw, sw, R-type, beq on consecutive cycles (OpValid=1) → each word appears exactly 1 cycle later:
  - sw: MemWrite=1, ImmSrc=01, ALUSrc=1, RegWrite=0
  - R-type: RegWrite=1, ALUOp=10, ALUSrc=0
  - beq: Branch=1, ImmSrc=10, ALUOp=01, RegWrite=0
- Op=1111111 with OpValid=1 → all controls 0, IllegalOp=1, CtrlValid=1.
- Op=0110011 with OpValid=0 → all controls 0, CtrlValid=0, IllegalOp=0.
- Op=0010011: with MAIN_DEC_ITYPE_EN defined → RegWrite=1, ALUSrc=1, ALUOp=10, IllegalOp=0. Without the macro → IllegalOp=1 and all controls 0.
- Stream of valid sw words, then rst=1 at cycle 3 → MemWrite=0 at the following edge and stays 0 while rst=1.
